// File: rtl/otp_stream_ctrl_pkg.sv
// Shared constants, state encoding and width helper for the one-time-pad
// stream controller.
package otp_pkg;

    localparam int KEY_SIZE_DEF = 16;
    localparam int MSG_SIZE_DEF = 240;
    localparam int NUM_WORDS    = MSG_SIZE_DEF / KEY_SIZE_DEF;

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } otp_state_t;

    // Keeps word_idx at least one bit wide when a message is a single word.
    function automatic int idx_width(input int num_words);
        return (num_words > 1) ? $clog2(num_words) : 1;
    endfunction

endpackage

// File: rtl/otp_stream_ctrl_if.sv
// Message-in / cipher-word-out handshake bundle for otp_stream_ctrl.
interface otp_stream_ctrl_if
    import otp_pkg::*;
#(
    parameter int KEY_SIZE = KEY_SIZE_DEF,
    parameter int MSG_SIZE = MSG_SIZE_DEF,
    parameter int IDX_W    = idx_width(MSG_SIZE / KEY_SIZE)
) ();

    logic                in_valid;
    logic                in_ready;
    logic [MSG_SIZE-1:0] in_msg;
    logic [KEY_SIZE-1:0] in_key;
    logic                abort;
    logic                out_valid;
    logic                out_ready;
    logic [KEY_SIZE-1:0] out_data;
    logic                out_last;
    logic [IDX_W-1:0]    word_idx;
    logic                msg_done;

    modport master (
        output in_valid, in_msg, in_key, abort, out_ready,
        input  in_ready, out_valid, out_data, out_last, word_idx, msg_done
    );

    modport slave (
        input  in_valid, in_msg, in_key, abort, out_ready,
        output in_ready, out_valid, out_data, out_last, word_idx, msg_done
    );

endinterface

// File: rtl/otp_stream_ctrl_shifter.sv
// Message register that presents its most significant word and shifts left
// one word at a time; load wins over shift.
module otp_word_shifter #(
    parameter int MSG_SIZE = 240,
    parameter int KEY_SIZE = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic                shift,
    input  logic [MSG_SIZE-1:0] load_data,
    output logic [KEY_SIZE-1:0] top_word
);

    logic [MSG_SIZE-1:0] shreg_q;
    logic [MSG_SIZE-1:0] shreg_d;

    always_comb begin
        shreg_d = shreg_q;
        if (load) begin
            shreg_d = load_data;
        end else if (shift) begin
            shreg_d = shreg_q << KEY_SIZE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg_q <= '0;
        end else begin
            shreg_q <= shreg_d;
        end
    end

    assign top_word = shreg_q[MSG_SIZE-1 -: KEY_SIZE];

endmodule

// File: rtl/otp_stream_ctrl.sv
// One-time-pad sequencer: latches a message and key, then streams
// key-sized cipher words MSB-first under downstream backpressure.
module otp_stream_ctrl
    import otp_pkg::*;
#(
    parameter int KEY_SIZE = KEY_SIZE_DEF,
    parameter int MSG_SIZE = MSG_SIZE_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    otp_stream_ctrl_if.slave      bus
);

    localparam int NUM_W = MSG_SIZE / KEY_SIZE;
    localparam int IDX_W = idx_width(NUM_W);

    generate
        if ((MSG_SIZE % KEY_SIZE) != 0) begin : g_size_check
            $error("otp_stream_ctrl: MSG_SIZE must be a multiple of KEY_SIZE");
        end
    endgenerate

    otp_state_t          state_q, state_d;
    logic [KEY_SIZE-1:0] key_q, key_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                done_q, done_d;
    logic                load, shift;
    logic                is_last;
    logic                in_ready_int;
    logic [KEY_SIZE-1:0] top_word;

    otp_word_shifter #(
        .MSG_SIZE (MSG_SIZE),
        .KEY_SIZE (KEY_SIZE)
    ) u_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .shift     (shift),
        .load_data (bus.in_msg),
        .top_word  (top_word)
    );

    assign is_last      = (idx_q == IDX_W'(NUM_W - 1));
    // abort is allowed to reach in_ready directly so it can veto acceptance.
    assign in_ready_int = (state_q == IDLE) && !bus.abort;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        load    = 1'b0;
        shift   = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.in_valid && in_ready_int) begin
                    state_d = STREAM;
                    key_d   = bus.in_key;
                    idx_d   = '0;
                    load    = 1'b1;
                end
            end
            STREAM: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.out_ready) begin
                    if (is_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        shift = 1'b1;
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            idx_q   <= idx_d;
            done_q  <= done_d;
        end
    end

    // Cipher word is forced to zero outside STREAM so idle output is clean.
    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = (state_q == STREAM);
    assign bus.out_data  = (state_q == STREAM) ? (top_word ^ key_q) : '0;
    assign bus.out_last  = (state_q == STREAM) && is_last;
    assign bus.word_idx  = idx_q;
    assign bus.msg_done  = done_q;

endmodule
